// File: rtl/bus_arbiter_if.sv
// Two-master / three-slave bus bundle for bus_arbiter.
// slave modport is the arbiter's view (it serves the masters); master is the environment's view.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic        m0_ack;
    logic        m1_ack;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] m_rdata;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_byteen;
    logic        s_dm_sel;
    logic        s_tc0_sel;
    logic        s_tc1_sel;
    logic [31:0] s_dm_rdata;
    logic [31:0] s_tc0_rdata;
    logic [31:0] s_tc1_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_byteen,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_byteen,
        input  s_dm_rdata, s_tc0_rdata, s_tc1_rdata,
        output m0_ack, m1_ack, m0_err, m1_err, m_rdata,
        output s_addr, s_wdata, s_byteen, s_dm_sel, s_tc0_sel, s_tc1_sel
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_byteen,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_byteen,
        output s_dm_rdata, s_tc0_rdata, s_tc1_rdata,
        input  m0_ack, m1_ack, m0_err, m1_err, m_rdata,
        input  s_addr, s_wdata, s_byteen, s_dm_sel, s_tc0_sel, s_tc1_sel
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with DM/TC0/TC1 address decode, 3-cycle IDLE/ACCESS/RESP transactions.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (m0 wins).
module bus_arbiter (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        lat_we_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic [3:0]  lat_byteen_q;
    logic        lat_idx_q;
    logic [31:0] rdata_q;

    logic        any_req;
    logic        grant_idx;
    logic        in_dm, in_tc0, in_tc1, in_tc;
    logic        is_cnt, is_word, acc_err;
    logic [31:0] sel_rdata;

    assign any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;  // 1: m1 wins the next tie

    assign grant_idx = bus.m0_req ? (bus.m1_req & rr_q) : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            rr_q <= ~grant_idx;
        end
    end
`else
    assign grant_idx = ~bus.m0_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_byteen_q <= '0;
            lat_idx_q    <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            lat_idx_q    <= grant_idx;
            lat_we_q     <= grant_idx ? bus.m1_we     : bus.m0_we;
            lat_addr_q   <= grant_idx ? bus.m1_addr   : bus.m0_addr;
            lat_wdata_q  <= grant_idx ? bus.m1_wdata  : bus.m0_wdata;
            lat_byteen_q <= grant_idx ? bus.m1_byteen : bus.m0_byteen;
        end
    end

    // Decode works on the latched fields, so it stays stable through ACCESS and RESP.
    always_comb begin
        in_dm   = (lat_addr_q <= 32'h0000_2FFF);
        in_tc0  = (lat_addr_q >= 32'h0000_7F00) && (lat_addr_q <= 32'h0000_7F0B);
        in_tc1  = (lat_addr_q >= 32'h0000_7F10) && (lat_addr_q <= 32'h0000_7F1B);
        in_tc   = in_tc0 | in_tc1;
        is_cnt  = in_tc && (lat_addr_q[3:2] == 2'b10);
        is_word = !lat_we_q || (lat_byteen_q == 4'b1111);
        acc_err = !(in_dm | in_tc)
                | (in_tc && lat_we_q && (lat_byteen_q != 4'b1111))
                | (is_cnt && lat_we_q)
                | (is_word && (lat_addr_q[1:0] != 2'b00));
        sel_rdata = '0;
        if (in_dm) begin
            sel_rdata = bus.s_dm_rdata;
        end else if (in_tc0) begin
            sel_rdata = bus.s_tc0_rdata;
        end else if (in_tc1) begin
            sel_rdata = bus.s_tc1_rdata;
        end
    end

    // m_rdata only carries data during RESP; errors read back as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (state_q == StAccess && !acc_err) begin
            rdata_q <= sel_rdata;
        end else begin
            rdata_q <= '0;
        end
    end

    assign bus.m_rdata = rdata_q;

    always_comb begin
        state_d       = state_q;
        bus.s_addr    = '0;
        bus.s_wdata   = '0;
        bus.s_byteen  = '0;
        bus.s_dm_sel  = 1'b0;
        bus.s_tc0_sel = 1'b0;
        bus.s_tc1_sel = 1'b0;
        bus.m0_ack    = 1'b0;
        bus.m1_ack    = 1'b0;
        bus.m0_err    = 1'b0;
        bus.m1_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) state_d = StAccess;
            end
            StAccess: begin
                state_d       = StResp;
                bus.s_addr    = lat_addr_q;
                bus.s_wdata   = lat_wdata_q;
                bus.s_byteen  = (lat_we_q && !acc_err) ? lat_byteen_q : 4'b0000;
                bus.s_dm_sel  = in_dm  && !acc_err;
                bus.s_tc0_sel = in_tc0 && !acc_err;
                bus.s_tc1_sel = in_tc1 && !acc_err;
            end
            StResp: begin
                state_d    = StIdle;
                bus.m0_ack = !lat_idx_q;
                bus.m1_ack = lat_idx_q;
                bus.m0_err = !lat_idx_q && acc_err;
                bus.m1_err = lat_idx_q && acc_err;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " acks"}, {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        check_eq({tag, " sels"}, {29'd0, bus.s_tc1_sel, bus.s_tc0_sel, bus.s_dm_sel}, 32'd0);
        check_eq({tag, " s_byteen"}, {28'd0, bus.s_byteen}, 32'd0);
        check_eq({tag, " s_addr"}, bus.s_addr, 32'd0);
    endtask

    task automatic set_req(input bit idx, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
        if (idx == 1'b0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
            bus.m0_wdata = wdata; bus.m0_byteen = be;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
            bus.m1_wdata = wdata; bus.m1_byteen = be;
        end
    endtask

    // One transaction from IDLE; req dropped once ACCESS is seen, which must not abort it.
    task automatic single(input string tag, input bit idx, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [2:0] exp_sel,
                          input logic [3:0] exp_be, input logic exp_err,
                          input logic [31:0] exp_rdata);
        set_req(idx, 1'b1, we, addr, wdata, be);
        tick();
        check_eq({tag, " sel"}, {29'd0, bus.s_tc1_sel, bus.s_tc0_sel, bus.s_dm_sel},
                 {29'd0, exp_sel});
        check_eq({tag, " s_byteen"}, {28'd0, bus.s_byteen}, {28'd0, exp_be});
        check_eq({tag, " s_addr"}, bus.s_addr, addr);
        check_eq({tag, " early ack"}, {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        set_req(idx, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check_eq({tag, " ack"}, {30'd0, bus.m1_ack, bus.m0_ack}, idx ? 32'd2 : 32'd1);
        check_eq({tag, " err"}, {30'd0, bus.m1_err, bus.m0_err},
                 exp_err ? (idx ? 32'd2 : 32'd1) : 32'd0);
        check_eq({tag, " m_rdata"}, bus.m_rdata, exp_rdata);
        tick();
        check_eq({tag, " idle acks"}, {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    endtask

    logic [1:0] exp_tie [3];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.s_dm_rdata  = 32'h1111_2222;
        bus.s_tc0_rdata = 32'h3333_4444;
        bus.s_tc1_rdata = 32'h0000_CAFE;
        #3;
        check_quiet("reset");
        check_eq("reset m_rdata", bus.m_rdata, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        single("dm_wr",    1'b0, 1'b1, 32'h0000_0010, 32'h1234, 4'b0011, 3'b001, 4'b0011, 1'b0,
               32'h1111_2222);
        single("tc1_rd",   1'b1, 1'b0, 32'h0000_7F14, 32'h0,    4'b0000, 3'b100, 4'b0000, 1'b0,
               32'h0000_CAFE);
        single("cnt_wr",   1'b0, 1'b1, 32'h0000_7F08, 32'h55,   4'b1111, 3'b000, 4'b0000, 1'b1,
               32'h0);
        single("unmap_rd", 1'b0, 1'b0, 32'h0000_4000, 32'h0,    4'b0000, 3'b000, 4'b0000, 1'b1,
               32'h0);
        single("tc0_part", 1'b1, 1'b1, 32'h0000_7F00, 32'h77,   4'b0011, 3'b000, 4'b0000, 1'b1,
               32'h0);
        single("misalign", 1'b0, 1'b0, 32'h0000_0012, 32'h0,    4'b0000, 3'b000, 4'b0000, 1'b1,
               32'h0);
        single("tc0_wr",   1'b1, 1'b1, 32'h0000_7F04, 32'h5,    4'b1111, 3'b010, 4'b1111, 1'b0,
               32'h3333_4444);
        single("dm_top",   1'b0, 1'b1, 32'h0000_2FFC, 32'h9,    4'b1100, 3'b001, 4'b1100, 1'b0,
               32'h1111_2222);
        single("dm_past",  1'b0, 1'b0, 32'h0000_3000, 32'h0,    4'b0000, 3'b000, 4'b0000, 1'b1,
               32'h0);
        single("cnt1_rd",  1'b1, 1'b0, 32'h0000_7F18, 32'h0,    4'b0000, 3'b100, 4'b0000, 1'b0,
               32'h0000_CAFE);
        single("cnt1_wr",  1'b1, 1'b1, 32'h0000_7F18, 32'h1,    4'b1111, 3'b000, 4'b0000, 1'b1,
               32'h0);

        // Ties: reset first so the pointer starts favouring m0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_tie[0] = 2'b01; exp_tie[1] = 2'b10; exp_tie[2] = 2'b01;
`else
        exp_tie[0] = 2'b01; exp_tie[1] = 2'b01; exp_tie[2] = 2'b01;
`endif
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000);
        set_req(1'b1, 1'b1, 1'b0, 32'h0000_7F04, 32'h0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("tie%0d sel", i),
                     {29'd0, bus.s_tc1_sel, bus.s_tc0_sel, bus.s_dm_sel},
                     exp_tie[i][1] ? 32'd2 : 32'd1);
            tick();
            check_eq($sformatf("tie%0d acks", i), {30'd0, bus.m1_ack, bus.m0_ack},
                     {30'd0, exp_tie[i]});
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // Reset during ACCESS of a DM write, then the held req is served again.
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'hABCD, 4'b1111);
        tick();
        check_eq("rst access dm_sel", {31'd0, bus.s_dm_sel}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("rst async");
        tick();
        check_eq("rst no ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        reset = 1'b1;
        tick();
        check_eq("reserve dm_sel", {31'd0, bus.s_dm_sel}, 32'd1);
        check_eq("reserve s_wdata", bus.s_wdata, 32'h0000_ABCD);
        tick();
        check_eq("reserve ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
